// File: rtl/mem_req_pkg.sv
// Shared types for the p_* port request master: FSM states and queued command layout.
// Latency: n/a (types and a pure packing helper only).
// Backpressure: n/a.
package mem_req_pkg;

  // Widths the command record is built with; the top defaults its ports to these.
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  rw;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Assemble a command record from the individual request fields.
  function automatic cmd_t pack_cmd(input logic rw,
                                    input logic [CMD_ADDR_W-1:0] addr,
                                    input logic [CMD_DATA_W-1:0] wdata);
    cmd_t c;
    c.rw    = rw;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered pointers and a combinational head read.
// Latency: a push at edge N is visible on dout / clears empty right after edge N.
// Backpressure: pushes while full and pops while empty are ignored; full does not look at a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_master.sv
// Queues read/write commands and drives them one at a time onto the p_* cache port, one response each.
// Latency: push at N -> strobe from N+1; p_ready at edge M -> rsp_valid from M; min 3 cycles per command.
// Backpressure: cmd_ready = FIFO not full; no new command issues while an unaccepted response is held.
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int DATA_W     = CMD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rw,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] p_a,
  output logic [DATA_W-1:0] p_dout,
  output logic              p_strobe,
  output logic              p_rw,
  input  logic [DATA_W-1:0] p_din,
  input  logic              p_ready,
  output logic              busy
);

  // The counter only has to reach TIMEOUT-1; the extra headroom keeps it from ever wrapping.
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CMD_W-1:0] fifo_din;
  logic [CMD_W-1:0] fifo_dout;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic             done_ok;
  logic             done_to;

  assign fifo_din  = pack_cmd(cmd_rw, cmd_addr, cmd_wdata);
  assign head      = cmd_t'(fifo_dout);
  assign cmd_ready = ~fifo_full;
  assign push      = cmd_valid & ~fifo_full;

  // The response register is free if empty or being drained at this very edge.
  assign slot_free = ~rsp_valid | rsp_ready;

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strobe follows the state register directly, so an async reset drops it at once.
  assign p_strobe = (state == REQ);
  assign busy     = ~fifo_empty | (state != IDLE) | rsp_valid;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle decisions; p_ready wins over a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (~fifo_empty && slot_free) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (p_ready) begin
          done_ok   = 1'b1;
          state_nxt = GAP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          done_to   = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        // One quiet cycle so a slow memory FSM can return to idle.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Port request registers: loaded on pop and held for the whole REQ state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p_a    <= '0;
      p_dout <= '0;
      p_rw   <= 1'b0;
    end else if (pop) begin
      p_a    <= head.addr;
      p_dout <= head.wdata;
      p_rw   <= head.rw;
    end
  end

  // Timeout counter: cleared on issue, counts each strobe cycle that does not end the transaction.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (pop) begin
      cnt <= '0;
    end else if ((state == REQ) && (state_nxt == REQ)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Single-entry response register; a reload on the same edge as a handshake takes precedence.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else if (done_ok || done_to) begin
      rsp_valid <= 1'b1;
      rsp_err   <= done_to;
      rsp_rw    <= p_rw;
      rsp_addr  <= p_a;
      rsp_rdata <= (done_ok && !p_rw) ? p_din : '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// Randomised bench for mem_req_master with a behavioural memory stub and an in-order response model.
// Latency: each command carries a chosen p_ready delay; the model predicts response and strobe length.
// Backpressure: rsp_ready is driven always-high, random or held low to exercise the single response slot.
module tb_mem_req_master;

  localparam int TO  = 16;
  localparam int DEP = 4;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_m_t;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
  } rsp_m_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_rw;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] p_a;
  logic [31:0] p_dout;
  logic        p_strobe;
  logic        p_rw;
  logic [31:0] p_din = '0;
  logic        p_ready = 1'b0;
  logic        busy;

  cmd_m_t      cmd_q[$];
  rsp_m_t      exp_q[$];
  int          lat_q[$];
  logic [31:0] smem [16];
  logic [31:0] mmem [16];

  int          checks = 0;
  int          errors = 0;
  int          pushes = 0;
  int          pops = 0;
  int          completions = 0;
  int          handshakes = 0;
  int          scnt = 0;
  int          last_len = 0;
  int          low_run = 100;
  int          rdy_mode = 0;
  logic        prev_strobe = 1'b0;
  cmd_m_t      cur;
  logic        last_rw = 1'b0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;
  logic [31:0] last_addr = '0;

  mem_req_master #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (DEP),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rw    (rsp_rw),
    .rsp_addr  (rsp_addr),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .p_a       (p_a),
    .p_dout    (p_dout),
    .p_strobe  (p_strobe),
    .p_rw      (p_rw),
    .p_din     (p_din),
    .p_ready   (p_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Record an accepted command in the model: response content follows from latency and model memory.
  task automatic push_cmd(input logic rw, input logic [3:0] idx, input logic [31:0] wdata, input int lat);
    int waited = 0;
    cmd_m_t c;
    rsp_m_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = {26'd0, idx, 2'b00};
    cmd_wdata = wdata;
    while (!cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check("push_accept", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    c.rw = rw; c.addr = {26'd0, idx, 2'b00}; c.wdata = wdata;
    e.rw = rw; e.addr = c.addr; e.err = (lat >= TO);
    e.rdata = (rw || e.err) ? 32'd0 : mmem[idx];
    if (rw && !e.err) mmem[idx] = wdata;
    cmd_q.push_back(c);
    exp_q.push_back(e);
    lat_q.push_back(lat);
    pushes++;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(n < 3000), 64'd1);
  endtask

  task automatic set_mem(input logic [3:0] idx, input logic [31:0] v);
    smem[idx] = v;
    mmem[idx] = v;
  endtask

  // Response consumer behaviour, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Memory stub: answers after the latency attached to the command, checks strobe length.
  always @(negedge clk) begin
    if (clr) begin
      p_ready = 1'b0;
      scnt    = 0;
    end else if (p_strobe) begin
      if (lat_q.size() == 0) begin
        check("stub_has_cmd", 64'(lat_q.size()), 64'd1);
        p_ready = 1'b0;
      end else begin
        p_din   = smem[p_a[5:2]];
        p_ready = (scnt == lat_q[0]);
        if (p_ready || scnt == TO - 1) begin
          last_len = scnt + 1;
          check("strobe_len", 64'(last_len), 64'((lat_q[0] >= TO) ? TO : lat_q[0] + 1));
          if (p_ready && p_rw) smem[p_a[5:2]] = p_dout;
          void'(lat_q.pop_front());
          scnt = 0;
        end else begin
          scnt++;
        end
      end
    end else begin
      p_ready = 1'b0;
      p_din   = $urandom;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    int occ;
    int outst;
    logic fall;
    rsp_m_t e;
    if (clr) begin
      prev_strobe = 1'b0;
      low_run     = 100;
    end else begin
      fall = prev_strobe && !p_strobe;
      if (p_strobe && !prev_strobe) begin
        pops++;
        check("issue_rsp_free", 64'(rsp_valid), 64'd0);
        check("issue_spacing", 64'(low_run >= 2), 64'd1);
        check("issue_expected", 64'(cmd_q.size() > 0), 64'd1);
        if (cmd_q.size() > 0) cur = cmd_q.pop_front();
      end
      if (p_strobe) begin
        check("p_a", 64'(p_a), 64'(cur.addr));
        check("p_rw", 64'(p_rw), 64'(cur.rw));
        check("p_dout", 64'(p_dout), 64'(cur.wdata));
        low_run = 0;
      end else begin
        low_run++;
      end
      if (fall) completions++;
      occ   = pushes - pops;
      outst = completions - handshakes;
      check("cmd_ready", 64'(cmd_ready), 64'(occ < DEP));
      check("rsp_valid", 64'(rsp_valid), 64'(outst > 0));
      check("busy", 64'(busy), 64'((occ > 0) || p_strobe || fall || (outst > 0)));
      if (rsp_valid) begin
        check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          check("rsp_rw", 64'(rsp_rw), 64'(e.rw));
          check("rsp_addr", 64'(rsp_addr), 64'(e.addr));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            handshakes++;
            last_rw    = rsp_rw;
            last_err   = rsp_err;
            last_rdata = rsp_rdata;
            last_addr  = rsp_addr;
          end
        end
      end
      prev_strobe = p_strobe;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int h0;
    int r;
    int lat;
    for (int i = 0; i < 16; i++) begin
      set_mem(4'(i), $urandom);
    end

    // Reset values while clr is held.
    #1;
    check("rst_strobe", 64'(p_strobe), 64'd0);
    check("rst_p_a", 64'(p_a), 64'd0);
    check("rst_p_dout", 64'(p_dout), 64'd0);
    check("rst_p_rw", 64'(p_rw), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_addr", 64'(rsp_addr), 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);

    // Read miss (slow) then hit (zero wait) to the same address.
    set_mem(4'h4, 32'hCAFE_0010);
    push_cmd(1'b0, 4'h4, 32'h0, 5);
    wait_drain();
    check("miss_len", 64'(last_len), 64'd6);
    check("miss_rdata", 64'(last_rdata), 64'hCAFE_0010);
    check("miss_err", 64'(last_err), 64'd0);
    push_cmd(1'b0, 4'h4, 32'h0, 0);
    wait_drain();
    check("hit_len", 64'(last_len), 64'd1);
    check("hit_rdata", 64'(last_rdata), 64'hCAFE_0010);

    // Write that never gets p_ready: full timeout.
    push_cmd(1'b1, 4'h2, 32'h0000_00AB, 100);
    wait_drain();
    check("to_len", 64'(last_len), 64'd16);
    check("to_err", 64'(last_err), 64'd1);
    check("to_rw", 64'(last_rw), 64'd1);
    check("to_rdata", 64'(last_rdata), 64'd0);
    check("to_addr", 64'(last_addr), 64'h08);

    // Zero-wait read of 0x04.
    set_mem(4'h1, 32'hDEAD_BEEF);
    push_cmd(1'b0, 4'h1, 32'h0, 0);
    wait_drain();
    check("zw_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    check("zw_len", 64'(last_len), 64'd1);

    // p_ready in the last allowed cycle beats the timeout.
    set_mem(4'h3, 32'h1234_5678);
    push_cmd(1'b0, 4'h3, 32'h0, TO - 1);
    wait_drain();
    check("edge_err", 64'(last_err), 64'd0);
    check("edge_rdata", 64'(last_rdata), 64'h1234_5678);
    check("edge_len", 64'(last_len), 64'd16);

    // Backpressure: response held, FIFO fills behind one in-flight command.
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    p0 = pops;
    h0 = handshakes;
    for (int i = 0; i < 5; i++) begin
      push_cmd(1'(i & 1), 4'(i + 8), $urandom, 2);
    end
    @(negedge clk);
    check("bp_full", 64'(cmd_ready), 64'd0);
    repeat (20) @(negedge clk);
    check("bp_single_issue", 64'(pops - p0), 64'd1);
    check("bp_rsp_held", 64'(rsp_valid), 64'd1);
    rdy_mode = 0;
    wait_drain();
    check("bp_all_rsp", 64'(handshakes - h0), 64'd5);

    // Randomised traffic with random consumer.
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      r = $urandom_range(0, 9);
      if (r < 6)       lat = $urandom_range(0, 3);
      else if (r == 6) lat = TO - 1;
      else if (r == 7) lat = TO;
      else if (r == 8) lat = $urandom_range(4, TO - 2);
      else             lat = 20;
      push_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, lat);
    end
    rdy_mode = 0;
    wait_drain();

    // Reset in the middle of a transaction with more commands queued.
    push_cmd(1'b0, 4'h5, 32'h0, 30);
    push_cmd(1'b1, 4'h6, 32'h55, 0);
    push_cmd(1'b0, 4'h7, 32'h0, 0);
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("mid_rst_strobe", 64'(p_strobe), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    cmd_q.delete();
    exp_q.delete();
    lat_q.delete();
    pushes = 0; pops = 0; completions = 0; handshakes = 0;
    for (int i = 0; i < 16; i++) mmem[i] = smem[i];
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(p_strobe), 64'd0);
    push_cmd(1'b0, 4'h4, 32'h0, 1);
    wait_drain();
    check("post_rst_rdata", 64'(last_rdata), 64'(smem[4]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
